// File: rtl/arf_wb_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arf_wb_sched_pkg
// Brief   : Shared widths and constants for the ARF write-back scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef RV32_ARF_SEL
`define RV32_ARF_SEL 5
`endif
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif
`ifndef ARF_WB_DEPTH
`define ARF_WB_DEPTH 4
`endif

package arf_wb_sched_pkg;
    localparam int c_ADDR_W = `RV32_ARF_SEL;
    localparam int c_DATA_W = `RV32_DATA_WIDTH;
    localparam int c_DEPTH  = `ARF_WB_DEPTH;
endpackage
`default_nettype wire

// File: rtl/arf_wb_sched_fwd_match.sv
`default_nettype none
// ============================================================================
// Module  : arf_fwd_match
// Brief   : Youngest-match search over pending write-back entries.
// Revision: 1.0 - initial release
// ============================================================================
module arf_fwd_match
    import arf_wb_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]               i_valid,
    input  logic [DEPTH-1:0][c_ADDR_W-1:0] i_addrs,
    input  logic [DEPTH-1:0][c_DATA_W-1:0] i_datas,
    input  logic [PTR_W-1:0]               i_head,
    input  logic [c_ADDR_W-1:0]            i_rd_addr,
    output logic                           o_hit,
    output logic [c_DATA_W-1:0]            o_data
);
    logic [PTR_W-1:0] w_slot;

    // Walk oldest to youngest so the last match found is the youngest.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_slot = i_head + i[PTR_W-1:0];
            if (i_valid[w_slot] && (i_addrs[w_slot] == i_rd_addr) &&
                (i_rd_addr != '0)) begin
                o_hit  = 1'b1;
                o_data = i_datas[w_slot];
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/arf_wb_sched.sv
`default_nettype none
// ============================================================================
// Module  : arf_wb_sched
// Brief   : Two-lane commit FIFO draining onto two regfile write ports.
// Revision: 1.0 - initial release
// ============================================================================
module arf_wb_sched
    import arf_wb_sched_pkg::*;
#(
    parameter int DEPTH = c_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_cmt_vld_0,
    input  logic [c_ADDR_W-1:0] i_cmt_addr_0,
    input  logic [c_DATA_W-1:0] i_cmt_data_0,
    input  logic                i_cmt_vld_1,
    input  logic [c_ADDR_W-1:0] i_cmt_addr_1,
    input  logic [c_DATA_W-1:0] i_cmt_data_1,
    output logic                o_cmt_rdy,
    input  logic                i_hold,
    output logic                o_wr_en_1,
    output logic [c_ADDR_W-1:0] o_wr_addr_1,
    output logic [c_DATA_W-1:0] o_wr_data_1,
    output logic                o_wr_en_2,
    output logic [c_ADDR_W-1:0] o_wr_addr_2,
    output logic [c_DATA_W-1:0] o_wr_data_2,
    input  logic [c_ADDR_W-1:0] i_rd_addr_1,
    input  logic [c_ADDR_W-1:0] i_rd_addr_2,
    input  logic [c_ADDR_W-1:0] i_rd_addr_3,
    input  logic [c_ADDR_W-1:0] i_rd_addr_4,
    output logic                o_fwd_hit_1,
    output logic                o_fwd_hit_2,
    output logic                o_fwd_hit_3,
    output logic                o_fwd_hit_4,
    output logic [c_DATA_W-1:0] o_fwd_data_1,
    output logic [c_DATA_W-1:0] o_fwd_data_2,
    output logic [c_DATA_W-1:0] o_fwd_data_3,
    output logic [c_DATA_W-1:0] o_fwd_data_4,
    output logic                o_empty
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [DEPTH-1:0][c_ADDR_W-1:0] r_addr;
    logic [DEPTH-1:0][c_DATA_W-1:0] r_data;
    logic [c_PTR_W-1:0]             r_head;
    logic [c_PTR_W-1:0]             r_tail;
    logic [c_CNT_W-1:0]             r_count;

    logic                           w_acc;
    logic                           w_st0;
    logic                           w_st1;
    logic [c_PTR_W-1:0]             w_tail1;
    logic [c_PTR_W-1:0]             w_head1;
    logic [1:0]                     w_nenq;
    logic [1:0]                     w_ndeq;
    logic [DEPTH-1:0]               w_valid;

    assign o_cmt_rdy = (r_count <= c_CNT_W'(DEPTH - 2));
    assign o_empty   = (r_count == '0);

    // x0 lanes are consumed but dropped; lane 1 packs behind lane 0 if stored.
    assign w_acc   = o_cmt_rdy & i_cmt_vld_0;
    assign w_st0   = w_acc & (i_cmt_addr_0 != '0);
    assign w_st1   = w_acc & i_cmt_vld_1 & (i_cmt_addr_1 != '0);
    assign w_nenq  = {1'b0, w_st0} + {1'b0, w_st1};
    assign w_tail1 = r_tail + c_PTR_W'(w_st0);
    assign w_head1 = r_head + c_PTR_W'(1);

    assign w_ndeq = i_hold ? 2'd0 :
                    (r_count >= c_CNT_W'(2)) ? 2'd2 : r_count[1:0];

    // Two drained writes to one register collapse onto the younger port.
    assign o_wr_en_2   = (w_ndeq == 2'd2);
    assign o_wr_en_1   = (w_ndeq != 2'd0) &&
                         !(o_wr_en_2 && (r_addr[r_head] == r_addr[w_head1]));
    assign o_wr_addr_1 = r_addr[r_head];
    assign o_wr_data_1 = r_data[r_head];
    assign o_wr_addr_2 = r_addr[w_head1];
    assign o_wr_data_2 = r_data[w_head1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + c_PTR_W'(w_ndeq);
            r_tail  <= r_tail + c_PTR_W'(w_nenq);
            r_count <= r_count + c_CNT_W'(w_nenq) - c_CNT_W'(w_ndeq);
        end
    end

    always_ff @(posedge clk) begin
        if (w_st0) begin
            r_addr[r_tail] <= i_cmt_addr_0;
            r_data[r_tail] <= i_cmt_data_0;
        end
        if (w_st1) begin
            r_addr[w_tail1] <= i_cmt_addr_1;
            r_data[w_tail1] <= i_cmt_data_1;
        end
    end

    generate
        for (genvar s = 0; s < DEPTH; s++) begin : g_vld
            logic [c_PTR_W-1:0] w_off;
            assign w_off      = c_PTR_W'(s) - r_head;
            assign w_valid[s] = ({1'b0, w_off} < r_count);
        end
    endgenerate

    logic [3:0][c_ADDR_W-1:0] w_rd_addr;
    logic [3:0]               w_hit;
    logic [3:0][c_DATA_W-1:0] w_fdata;

    assign w_rd_addr = {i_rd_addr_4, i_rd_addr_3, i_rd_addr_2, i_rd_addr_1};

    generate
        for (genvar k = 0; k < 4; k++) begin : g_fwd
            arf_fwd_match #(
                .DEPTH (DEPTH)
            ) u_match (
                .i_valid   (w_valid),
                .i_addrs   (r_addr),
                .i_datas   (r_data),
                .i_head    (r_head),
                .i_rd_addr (w_rd_addr[k]),
                .o_hit     (w_hit[k]),
                .o_data    (w_fdata[k])
            );
        end
    endgenerate

    assign o_fwd_hit_1  = w_hit[0];
    assign o_fwd_hit_2  = w_hit[1];
    assign o_fwd_hit_3  = w_hit[2];
    assign o_fwd_hit_4  = w_hit[3];
    assign o_fwd_data_1 = w_fdata[0];
    assign o_fwd_data_2 = w_fdata[1];
    assign o_fwd_data_3 = w_fdata[2];
    assign o_fwd_data_4 = w_fdata[3];
endmodule
`default_nettype wire

// File: doc/arf_wb_sched.md
# arf_wb_sched

Write-back scheduler for the architectural register file. Accepts up to two in-order committed results per cycle from the ROB commit stage, buffers them in a small FIFO, and drains up to two per cycle onto the regfile's two write ports. Also forwards pending values to the four regfile read ports. Sits between ROB commit and the regfile.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  reset; synchronous, active-low (already decided)
- i_cmt_vld_0  in  1  commit lane 0 valid (older)
- i_cmt_addr_0  in  `RV32_ARF_SEL`  lane 0 destination
- i_cmt_data_0  in  `RV32_DATA_WIDTH`  lane 0 result
- i_cmt_vld_1  in  1  commit lane 1 valid (younger); legal only when i_cmt_vld_0=1
- i_cmt_addr_1  in  `RV32_ARF_SEL`  lane 1 destination
- i_cmt_data_1  in  `RV32_DATA_WIDTH`  lane 1 result
- o_cmt_rdy  out  1  both lanes may be accepted this cycle
- i_hold  in  1  suppress draining (debug/checkpoint)
- o_wr_en_1, o_wr_addr_1, o_wr_data_1  out  1/`RV32_ARF_SEL`/`RV32_DATA_WIDTH`  regfile write port 1 (older)
- o_wr_en_2, o_wr_addr_2, o_wr_data_2  out  same  regfile write port 2 (younger)
- i_rd_addr_1..4  in  `RV32_ARF_SEL`  copies of the regfile read addresses
- o_fwd_hit_1..4  out  1  pending write to that address exists
- o_fwd_data_1..4  out  `RV32_DATA_WIDTH`  youngest pending value for that address
- o_empty  out  1  no pending writes

## Operation
- State: DEPTH-entry circular buffer {addr, data}, head pointer, tail pointer, count (width clog2(DEPTH)+1).
- o_cmt_rdy = (DEPTH - count) >= 2. Computed from registered count only, with no combinational path from i_cmt_*.
- Enqueue when o_cmt_rdy & i_cmt_vld_0. Lane 0 is written at tail; lane 1 (if valid) at tail+1.
- Lanes with addr==0 are consumed but not stored. n_enq is 0..2 after the x0 filter, and the stored order is preserved.
- Drain when !i_hold: n_deq = min(count, 2).
  - Port 1 = head entry; port 2 = head+1 entry.
  - o_wr_en_* are driven combinationally from the registered FIFO state, so no path exists from i_cmt_* to the write ports.
- Same-address collapse: if n_deq==2 and both drained addresses are equal, o_wr_en_1=0 and o_wr_en_2=1. Both entries still pop.
- If n_deq==1, only port 1 is used; o_wr_en_2=0.
- count_next = count + n_enq - n_deq. Pointers wrap modulo DEPTH. Simultaneous enqueue and drain is always legal.
- Forwarding: for each read port k, compare i_rd_addr_k against all valid entries; the youngest match wins.
  - addr 0 never hits.
  - Entries draining this cycle still forward, because the regfile has not yet been updated.
  - Forwarding is purely combinational on read address and registered FIFO state.
- Reset (rst_n=0 at posedge): count=0, head=tail=0, so o_cmt_rdy=1, o_wr_en_*=0, o_fwd_hit_*=0, o_empty=1. Entry data is not reset. A reset mid-drain discards all pending entries.

## Timing
- Commit accepted at edge t. The entry is visible on o_wr_* and o_fwd_* in cycle t+1, and the regfile is updated at edge t+1 when there is no hold and the entry is at the head.
- Throughput: 2 writes/cycle sustained. With count=0 and two-lane commits every cycle, o_cmt_rdy stays 1.
- With i_hold=1, the FIFO fills. o_cmt_rdy falls in the cycle after count exceeds DEPTH-2.
- i_hold takes effect in the same cycle: o_wr_en_*=0 combinationally.

## Structure
- Add `ARF_WB_DEPTH` to constants.vh next to `RV32_ARF_SEL` / `RV32_DATA_WIDTH`. The address and data widths come only from there.
- One sub-module, arf_fwd_match: a DEPTH-entry youngest-match priority search taking {valid mask, addrs, datas, head, rd_addr} and returning {hit, data}. Instantiate it 4 times.
- The top level holds the FIFO, count/pointer logic, drain and collapse logic.

## Test plan
- Reset, then a two-lane commit {x5=0x11, x6=0x22} → next cycle wr_en_1=1 addr 5 data 0x11 and wr_en_2=1 addr 6 data 0x22; o_empty=1 the cycle after.
- Commit {x7=0xA, x7=0xB} → wr_en_1=0, wr_en_2=1 with addr 7 data 0xB; a read of x7 in the drain cycle forwards hit=1 with 0xB.
- Commit {x0=0xFF, x3=0x33} → only x3 is stored; port 1 writes x3=0x33; a read of x0 gives hit=0.
- i_hold=1 with 3 single-lane commits at DEPTH=4 → o_cmt_rdy=0 once count=3. Release hold → two writes, then one; o_cmt_rdy returns to 1.
- Back-to-back two-lane commits for 10 cycles with no hold → exactly 20 ordered writes, pointers wrap, o_cmt_rdy stays 1.
- rst_n=0 with 3 entries pending → next cycle o_empty=1, no wr_en, and all fwd_hit=0.
